fsm_3_driver: RTL

- Stimulus-side counterpart of the four-state FSM (`fsm_3`): inputs A/B/C/D, 2-bit state output `out`.
- Accepts a requested target state over a valid/ready handshake and drives A/B/C/D (plus the FSM's reset) hop by hop to steer the FSM there.
- Checks the FSM's reported state after every hop; any deviation is flagged as an error.
- Used as a reusable steering/checking agent in the FSM security-verification environment.

---
 rtl/fsm_3_driver.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fsm_3_driver.sv
// Steering/checking agent for the four-state fsm_3. Accepts a target state over a
// valid/ready handshake, drives A/B/C (or the FSM reset) one hop at a time, checks the
// reported state after every hop and reports done/err with the offending state.
module fsm_3_driver #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned MAX_HOPS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       fsm_rst,
  input  logic [1:0] fsm_out,
  output logic       done,
  output logic       err,
  output logic [1:0] err_state
);

  localparam int unsigned HopW = $clog2(MAX_HOPS + 1);
  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam logic [HopW-1:0] MaxHops = HopW'(MAX_HOPS);
  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StPlan, StStep, StReset, StCheck, StDone, StFail
  } state_e;

  typedef enum logic [1:0] {SelNone, SelA, SelB, SelC} sel_e;

  state_e          state_q, state_d;
  sel_e            sel_q, sel_d;
  logic [1:0]      target_q, target_d;
  logic [1:0]      exp_q, exp_d;
  logic [HopW-1:0] hops_q, hops_d;
  logic [RstW-1:0] rcnt_q, rcnt_d;

  logic req_ready_q, req_ready_d;
  logic a_q, a_d, b_q, b_d, c_q, c_d;
  logic fsm_rst_q, fsm_rst_d;
  logic done_q, done_d, err_q, err_d;
  logic [1:0] err_state_q, err_state_d;

  // Next-state: accept, plan one hop from the observed state, drive it, then check.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    target_d    = target_q;
    exp_d       = exp_q;
    hops_d      = hops_q;
    rcnt_d      = rcnt_q;
    err_state_d = err_state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          target_d = req_target;
          hops_d   = '0;
          state_d  = StPlan;
        end
      end
      StPlan: begin
        if (fsm_out == target_q) begin
          state_d = StDone;
        end else if (hops_q == MaxHops) begin
          state_d     = StFail;
          err_state_d = fsm_out;
        end else begin
          hops_d = hops_q + 1'b1;
          // S1 is absorbing, and S0 is only reachable through reset.
          if (fsm_out == S1 || target_q == S0) begin
            state_d = StReset;
            exp_d   = S0;
            rcnt_d  = '0;
          end else begin
            state_d = StStep;
            unique case (fsm_out)
              S0: begin
                if (target_q == S1) begin
                  sel_d = SelB;
                  exp_d = S1;
                end else begin
                  sel_d = SelC;
                  exp_d = S2;
                end
              end
              S2: begin
                if (target_q == S1) begin
                  sel_d = SelB;
                  exp_d = S1;
                end else begin
                  sel_d = SelA;
                  exp_d = S3;
                end
              end
              default: begin
                // S3 decays to S2 with all inputs low.
                sel_d = SelNone;
                exp_d = S2;
              end
            endcase
          end
        end
      end
      StStep: state_d = StCheck;
      StReset: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == RstLast) state_d = StCheck;
      end
      StCheck: begin
        if (fsm_out == exp_q) begin
          state_d = StPlan;
        end else begin
          state_d     = StFail;
          err_state_d = fsm_out;
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so all outputs register.
  always_comb begin
    req_ready_d = (state_d == StIdle);
    fsm_rst_d   = (state_d == StReset);
    done_d      = (state_d == StDone) || (state_d == StFail);
    err_d       = (state_d == StFail);
    a_d         = 1'b0;
    b_d         = 1'b0;
    c_d         = 1'b0;
    unique case (state_d)
      StStep: begin
        a_d = (sel_d == SelA);
        b_d = (sel_d == SelB);
        c_d = (sel_d == SelC);
      end
      StReset: ;
      // fsm_out has not moved yet at the edge entering CHECK, so hold the expected state.
      StCheck: a_d = (exp_d == S3);
      // Keep S3 from decaying while idle or deciding.
      default: a_d = (fsm_out == S3);
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= SelNone;
      target_q    <= S0;
      exp_q       <= S0;
      hops_q      <= '0;
      rcnt_q      <= '0;
      req_ready_q <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      c_q         <= 1'b0;
      fsm_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_state_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      target_q    <= target_d;
      exp_q       <= exp_d;
      hops_q      <= hops_d;
      rcnt_q      <= rcnt_d;
      req_ready_q <= req_ready_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      fsm_rst_q   <= fsm_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_state_q <= err_state_d;
    end
  end

  assign req_ready = req_ready_q;
  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;
  assign D         = 1'b0;
  assign fsm_rst   = fsm_rst_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_state = err_state_q;

endmodule
